ft245_frame_receiver: RTL and testbench

//  Reads bytes from the FT245 USB FIFO, parses row frames and emits 32-bit

---
 rtl/ft245_frame_receiver.sv | 199 +++++++++++++++++++
 tb/tb_ft245_frame_receiver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_frame_receiver.sv
// ft245_frame_receiver
//   Front-end of the USB path. Pulls bytes out of an FT245 FIFO and parses
//   row frames. A frame is one header byte followed by 64 data bytes. The
//   data bytes are packed into 16 chunks of 4 bytes, first byte in bits
//   [31:24], and each chunk is written to led_controller's frame buffer.
//   All FT245 inputs are raw pins and are synchronised here.
// Ports
//   clk, reset          system clock, async active-high reset
//   rxf_n_raw           FT245 RXF# (low = byte available), async
//   data_bus_raw[7:0]   FT245 D[7:0], async
//   accept_en           0 stalls new reads (backpressure)
//   rd_n                FT245 RD#, registered
//   chunk_data/addr     assembled chunk and its index within the row
//   chunk_write_enable  1-cycle write strobe
//   row_addr/panel_addr taken from header[3:0] / header[5:4]
//   frame_done          pulses together with the strobe for chunk 15
//   frame_error         pulses on a bad header or an inter-byte timeout
//   state_out           {rxf_sync, sticky_err, in_frame, bus_state[1:0]}
module ft245_frame_receiver #(
  parameter int RD_LOW_CYCLES  = 4,
  parameter int RD_HIGH_CYCLES = 5,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxf_n_raw,
  input  logic [7:0]  data_bus_raw,
  input  logic        accept_en,
  output logic        rd_n,
  output logic [31:0] chunk_data,
  output logic [3:0]  chunk_addr,
  output logic        chunk_write_enable,
  output logic [3:0]  row_addr,
  output logic [1:0]  panel_addr,
  output logic        frame_done,
  output logic        frame_error,
  output logic [4:0]  state_out
);
  localparam int CNT_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOW_LAST  = CW'(RD_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(RD_HIGH_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] BUS_IDLE    = 2'd0;
  localparam logic [1:0] BUS_RD_LOW  = 2'd1;
  localparam logic [1:0] BUS_RD_HIGH = 2'd2;
  localparam logic [0:0] P_HUNT      = 1'b0;
  localparam logic [0:0] P_DATA      = 1'b1;

  // Synchronisers: rxf idles high (no data), the data bus idles at zero.
  logic       rxf_meta, rxf_s;
  logic [7:0] data_meta, data_s;
  logic       rxf_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxf_meta  <= 1'b1;
      rxf_s     <= 1'b1;
      data_meta <= 8'h00;
      data_s    <= 8'h00;
    end else begin
      rxf_meta  <= rxf_n_raw;
      rxf_s     <= rxf_meta;
      data_meta <= data_bus_raw;
      data_s    <= data_meta;
    end
  end

  assign rxf_sync = ~rxf_s;

  // Bus FSM. accept_en is only looked at in IDLE, so a read that has
  // already started always runs to completion.
  logic [1:0]    bus_state;
  logic [CW-1:0] cnt;
  logic [7:0]    byte_q;
  logic          byte_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_state <= BUS_IDLE;
      cnt       <= '0;
      rd_n      <= 1'b1;
      byte_q    <= 8'h00;
      byte_v    <= 1'b0;
    end else begin
      byte_v <= 1'b0;
      case (bus_state)
        BUS_IDLE: begin
          if (rxf_sync && accept_en) begin
            bus_state <= BUS_RD_LOW;
            rd_n      <= 1'b0;
            cnt       <= '0;
          end
        end
        BUS_RD_LOW: begin
          if (cnt == LOW_LAST) begin
            byte_q    <= data_s;
            byte_v    <= 1'b1;
            rd_n      <= 1'b1;
            cnt       <= '0;
            bus_state <= BUS_RD_HIGH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BUS_RD_HIGH: begin
          // This gap covers the RXF# deassert and the synchroniser lag, so a
          // stale rxf_sync cannot trigger a read of an empty FIFO.
          if (cnt == HIGH_LAST) begin
            cnt       <= '0;
            bus_state <= BUS_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          bus_state <= BUS_IDLE;
          rd_n      <= 1'b1;
          cnt       <= '0;
        end
      endcase
    end
  end

  // Frame parser
  logic [0:0]    pstate;
  logic [5:0]    byte_cnt;
  logic [23:0]   sreg;
  logic [TW-1:0] idle_cnt;
  logic          sticky_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstate             <= P_HUNT;
      byte_cnt           <= 6'd0;
      sreg               <= 24'h0;
      idle_cnt           <= '0;
      sticky_err         <= 1'b0;
      chunk_data         <= 32'h0;
      chunk_addr         <= 4'h0;
      chunk_write_enable <= 1'b0;
      row_addr           <= 4'h0;
      panel_addr         <= 2'd0;
      frame_done         <= 1'b0;
      frame_error        <= 1'b0;
    end else begin
      chunk_write_enable <= 1'b0;
      frame_done         <= 1'b0;
      frame_error        <= 1'b0;
      case (pstate)
        P_HUNT: begin
          if (byte_v) begin
            if (byte_q[7:6] == 2'b10) begin
              row_addr   <= byte_q[3:0];
              panel_addr <= byte_q[5:4];
              byte_cnt   <= 6'd0;
              idle_cnt   <= '0;
              pstate     <= P_DATA;
            end else begin
              frame_error <= 1'b1;
              sticky_err  <= 1'b1;
            end
          end
        end
        default: begin
          if (byte_v) begin
            // A byte arriving on the timeout cycle wins.
            idle_cnt <= '0;
            sreg     <= {sreg[15:0], byte_q};
            byte_cnt <= byte_cnt + 6'd1;
            if (byte_cnt[1:0] == 2'b11) begin
              chunk_data         <= {sreg, byte_q};
              chunk_addr         <= byte_cnt[5:2];
              chunk_write_enable <= 1'b1;
              if (byte_cnt == 6'd63) begin
                frame_done <= 1'b1;
                pstate     <= P_HUNT;
              end
            end
          end else if (idle_cnt == TO_MAX) begin
            // Partial chunk is dropped; the stale shift register is fully
            // overwritten before the next chunk of a new frame is emitted.
            frame_error <= 1'b1;
            sticky_err  <= 1'b1;
            pstate      <= P_HUNT;
          end else if (accept_en) begin
            // A stall is not a timeout, so the count is frozen during it.
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
      endcase
    end
  end

  assign state_out = {rxf_sync, sticky_err, (pstate == P_DATA), bus_state};

endmodule

// File: tb/tb_ft245_frame_receiver.sv
module tb_ft245_frame_receiver;
  localparam int TO = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxf_n_raw;
  logic [7:0]  data_bus_raw;
  logic        accept_en;
  logic        rd_n;
  logic [31:0] chunk_data;
  logic [3:0]  chunk_addr;
  logic        chunk_write_enable;
  logic [3:0]  row_addr;
  logic [1:0]  panel_addr;
  logic        frame_done;
  logic        frame_error;
  logic [4:0]  state_out;

  ft245_frame_receiver #(
    .RD_LOW_CYCLES (4),
    .RD_HIGH_CYCLES(5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rxf_n_raw         (rxf_n_raw),
    .data_bus_raw      (data_bus_raw),
    .accept_en         (accept_en),
    .rd_n              (rd_n),
    .chunk_data        (chunk_data),
    .chunk_addr        (chunk_addr),
    .chunk_write_enable(chunk_write_enable),
    .row_addr          (row_addr),
    .panel_addr        (panel_addr),
    .frame_done        (frame_done),
    .frame_error       (frame_error),
    .state_out         (state_out)
  );

  always #10 clk = ~clk;

  // FT245 model: head of the queue on the bus, pop on each RD# rising edge.
  logic [7:0] fifo[$];
  int  pops = 0, underflow = 0;
  bit  armed = 0;

  always @(negedge clk) begin
    rxf_n_raw    = (fifo.size() == 0);
    data_bus_raw = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  always @(posedge rd_n) begin
    if (armed && !reset) begin
      pops++;
      if (fifo.size() != 0) void'(fifo.pop_front());
      else underflow++;
    end
  end

  // Monitor: strobe log, pulse counts, rd_n low/high run lengths.
  typedef struct { logic [3:0] addr; logic [31:0] data; logic done; } strb_t;
  strb_t slog[$];
  int done_cnt = 0, err_cnt = 0;
  int lo_run = 0, hi_run = 0, lo_min = 999, lo_max = 0, hi_min = 999;
  bit seen_low = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (chunk_write_enable) slog.push_back('{chunk_addr, chunk_data, frame_done});
      if (frame_done)  done_cnt++;
      if (frame_error) err_cnt++;
      if (!rd_n) begin
        if (hi_run > 0 && seen_low && hi_run < hi_min) hi_min = hi_run;
        hi_run = 0; lo_run++; seen_low = 1;
      end else begin
        if (lo_run > 0) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        lo_run = 0; hi_run++;
      end
    end
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int n, input logic [7:0] base);
    fifo.push_back(hdr);
    for (int i = 0; i < n; i++) fifo.push_back(base + 8'(i));
  endtask

  task automatic drain(input int tail);
    for (int i = 0; i < 20000 && fifo.size() != 0; i++) @(negedge clk);
    if (fifo.size() != 0) chk("drain_timeout", fifo.size(), 0);
    repeat (tail) @(negedge clk);
  endtask

  task automatic clear_log();
    slog.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic check_frame(input string tag, input int nstrb, input logic [7:0] base,
                             input int ndone, input int nerr, input logic [3:0] row,
                             input logic [1:0] pnl, input logic sticky);
    chk({tag, "_nstrobe"}, slog.size(), nstrb);
    for (int k = 0; k < slog.size() && k < nstrb; k++) begin
      logic [7:0] b0;
      b0 = base + 8'(4 * k);
      chk({tag, "_addr"}, 32'(slog[k].addr), k);
      chk({tag, "_data"}, slog[k].data, {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3});
    end
    if (nstrb == 16 && slog.size() == 16) chk({tag, "_done_with_last"}, 32'(slog[15].done), 1);
    chk({tag, "_done_cnt"}, done_cnt, ndone);
    chk({tag, "_err_cnt"}, err_cnt, nerr);
    chk({tag, "_row"}, 32'(row_addr), 32'(row));
    chk({tag, "_panel"}, 32'(panel_addr), 32'(pnl));
    chk({tag, "_sticky"}, 32'(state_out[3]), 32'(sticky));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_n"}, 32'(rd_n), 1);
    chk({tag, "_we"}, 32'(chunk_write_enable), 0);
    chk({tag, "_cdata"}, chunk_data, 0);
    chk({tag, "_caddr"}, 32'(chunk_addr), 0);
    chk({tag, "_row"}, 32'(row_addr), 0);
    chk({tag, "_panel"}, 32'(panel_addr), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_err"}, 32'(frame_error), 0);
    chk({tag, "_state"}, 32'(state_out), 0);
  endtask

  typedef struct {
    logic [7:0] hdr; int ndata; logic [7:0] base;
    int strb; int done; int err; logic [3:0] row; logic [1:0] panel; logic sticky;
  } vec_t;
  vec_t vt[6];

  initial begin
    vt[0] = '{8'h9A, 64, 8'h00, 16, 1, 0, 4'hA, 2'd1, 1'b0};  // spec frame 0x00..0x3F
    vt[1] = '{8'h5A,  0, 8'h00,  0, 0, 1, 4'hA, 2'd1, 1'b1};  // bad header dropped
    vt[2] = '{8'h80, 64, 8'h40, 16, 1, 0, 4'h0, 2'd0, 1'b1};  // row 0 panel 0
    vt[3] = '{8'hBF, 64, 8'hC0, 16, 1, 0, 4'hF, 2'd3, 1'b1};  // max row/panel
    vt[4] = '{8'hC1,  0, 8'h00,  0, 0, 1, 4'hF, 2'd3, 1'b1};  // [7:6]=11 rejected
    vt[5] = '{8'hA5, 64, 8'hF0, 16, 1, 0, 4'h5, 2'd2, 1'b1};  // data wraps FF->00

    reset = 1'b1;
    accept_en = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    armed = 1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_read_when_empty", pops, 0);
    chk("idle_rd_n", 32'(rd_n), 1);

    for (int i = 0; i < 6; i++) begin
      clear_log();
      send_frame(vt[i].hdr, vt[i].ndata, vt[i].base);
      drain(60);
      check_frame($sformatf("vec%0d", i), vt[i].strb, vt[i].base, vt[i].done,
                  vt[i].err, vt[i].row, vt[i].panel, vt[i].sticky);
    end
    chk("no_underflow", underflow, 0);
    chk("rd_low_min", lo_min, 4);
    chk("rd_low_max", lo_max, 4);
    chk("rd_high_ge5", 32'(hi_min >= 5), 1);

    // Timeout after 6 data bytes: only chunk 0 written.
    clear_log();
    send_frame(8'h9A, 6, 8'h00);
    drain(TO + 60);
    check_frame("timeout", 1, 8'h00, 0, 1, 4'hA, 2'd1, 1'b1);
    chk("timeout_in_frame", 32'(state_out[2]), 0);
    clear_log();
    send_frame(8'hA3, 64, 8'h55);
    drain(60);
    check_frame("after_timeout", 16, 8'h55, 1, 0, 4'h3, 2'd2, 1'b1);

    // Long stall mid-frame with data available.
    begin
      int p0, w;
      clear_log();
      send_frame(8'h96, 64, 8'h80);
      w = 0;
      while (pops < 20 && w < 2000) begin @(negedge clk); w++; end
      if (pops < 20) chk("stall_start_timeout", pops, 20);
      accept_en = 1'b0;
      repeat (20) @(negedge clk);
      p0 = pops;
      repeat (TO * 7) @(negedge clk);
      chk("stall_no_reads", pops, p0);
      chk("stall_rd_n", 32'(rd_n), 1);
      chk("stall_no_timeout", err_cnt, 0);
      accept_en = 1'b1;
      drain(60);
      check_frame("stall", 16, 8'h80, 1, 0, 4'h6, 2'd1, 1'b1);
    end

    // Reset while rd_n is low during chunk 7.
    begin
      int w;
      clear_log();
      send_frame(8'h9A, 64, 8'h20);
      w = 0;
      while (slog.size() < 7 && w < 2000) begin @(negedge clk); w++; end
      if (slog.size() < 7) chk("reset_wait_chunk7", slog.size(), 7);
      w = 0;
      while (rd_n && w < 100) begin @(negedge clk); w++; end
      chk("reset_rd_low_seen", 32'(rd_n), 0);
      reset = 1'b1;
      #1;
      check_reset_outputs("midread_reset");
      fifo.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      clear_log();
      repeat (5) @(negedge clk);
      send_frame(8'h9A, 64, 8'h20);
      drain(60);
      check_frame("post_reset", 16, 8'h20, 1, 0, 4'hA, 2'd1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
